// File: rtl/vga_fb_port_ctrl_if.sv
// Framebuffer write/read port bundle: MCU pixel requests, fill engine control
// and the RAM WE/WA1/WD/RD1 port. The controller takes the slave side; the
// MCU-side logic together with the framebuffer RAM form the master side.
interface vga_fb_port_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              MCU_WE;
  logic              MCU_RE;
  logic [8:0]        MCU_X;
  logic [7:0]        MCU_Y;
  logic [DATA_W-1:0] MCU_WD;
  logic [DATA_W-1:0] MCU_RD;
  logic              MCU_RD_VALID;
  logic              MCU_BUSY;
  logic              FILL_START;
  logic [DATA_W-1:0] FILL_COLOR;
  logic              FILL_DONE;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_WA1;
  logic [DATA_W-1:0] RAM_WD;
  logic [DATA_W-1:0] RAM_RD1;

  modport master (
    output MCU_WE, MCU_RE, MCU_X, MCU_Y, MCU_WD, FILL_START, FILL_COLOR, RAM_RD1,
    input  MCU_RD, MCU_RD_VALID, MCU_BUSY, FILL_DONE, RAM_WE, RAM_WA1, RAM_WD
  );

  modport slave (
    input  MCU_WE, MCU_RE, MCU_X, MCU_Y, MCU_WD, FILL_START, FILL_COLOR, RAM_RD1,
    output MCU_RD, MCU_RD_VALID, MCU_BUSY, FILL_DONE, RAM_WE, RAM_WA1, RAM_WD
  );
endinterface

// File: rtl/vga_fb_port_ctrl.sv
// Framebuffer RAM port sequencer: arbitrates the single WE/WA1/WD/RD1 port
// between MCU pixel accesses and a full-screen fill engine.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | accepts MCU write/read or a fill; writes complete in one cycle
// RD_ADDR | read address is on RAM_WA1, RAM is producing RD1
// RD_DATA | RD1 valid, latch it into MCU_RD and pulse MCU_RD_VALID
// FILL    | one pixel written per cycle, addresses 0..WIDTH*HEIGHT-1
module vga_fb_port_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic CLK_50MHz,
  input  logic RST_N,
  vga_fb_port_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, FILL} state_t;

  state_t            state;
  logic              fill_pend;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_color;
  logic              rd_oor;

  logic [ADDR_W-1:0] mcu_addr;
  logic              mcu_in_range;

  assign mcu_addr     = ADDR_W'(bus.MCU_Y) * ADDR_W'(WIDTH) + ADDR_W'(bus.MCU_X);
  assign mcu_in_range = (int'(bus.MCU_X) < WIDTH) && (int'(bus.MCU_Y) < HEIGHT);

  // A pending fill keeps the MCU locked out so it cannot be starved by requests.
  assign bus.MCU_BUSY = (state != IDLE) || fill_pend;

  // Port sequencer: arbitration, read pipeline and fill address generation.
  always_ff @(posedge CLK_50MHz) begin
    if (!RST_N) begin
      state            <= IDLE;
      fill_pend        <= 1'b0;
      fill_cnt         <= '0;
      fill_color       <= '0;
      rd_oor           <= 1'b0;
      bus.RAM_WE       <= 1'b0;
      bus.RAM_WA1      <= '0;
      bus.RAM_WD       <= '0;
      bus.MCU_RD       <= '0;
      bus.MCU_RD_VALID <= 1'b0;
      bus.FILL_DONE    <= 1'b0;
    end else begin
      bus.RAM_WE       <= 1'b0;
      bus.MCU_RD_VALID <= 1'b0;
      bus.FILL_DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_pend || (bus.FILL_START && !bus.MCU_WE && !bus.MCU_RE)) begin
            // First fill pixel goes out on this edge so writes are back-to-back.
            fill_pend   <= 1'b0;
            fill_color  <= bus.FILL_COLOR;
            fill_cnt    <= '0;
            bus.RAM_WE  <= 1'b1;
            bus.RAM_WA1 <= '0;
            bus.RAM_WD  <= bus.FILL_COLOR;
            state       <= FILL;
          end else if (bus.MCU_WE) begin
            if (mcu_in_range) begin
              bus.RAM_WE  <= 1'b1;
              bus.RAM_WA1 <= mcu_addr;
              bus.RAM_WD  <= bus.MCU_WD;
            end
            if (bus.FILL_START) fill_pend <= 1'b1;
          end else if (bus.MCU_RE) begin
            bus.RAM_WA1 <= mcu_addr;
            rd_oor      <= !mcu_in_range;
            state       <= RD_ADDR;
            if (bus.FILL_START) fill_pend <= 1'b1;
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          bus.MCU_RD       <= rd_oor ? '0 : bus.RAM_RD1;
          bus.MCU_RD_VALID <= 1'b1;
          state            <= IDLE;
        end
        FILL: begin
          if (fill_cnt == LAST_PIX) begin
            bus.FILL_DONE <= 1'b1;
            state         <= IDLE;
          end else begin
            fill_cnt    <= fill_cnt + 1'b1;
            bus.RAM_WE  <= 1'b1;
            bus.RAM_WA1 <= fill_cnt + 1'b1;
            bus.RAM_WD  <= fill_color;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_port_ctrl.sv
// Bench for vga_fb_port_ctrl: framebuffer RAM model plus a pixel-array
// reference built from (X,Y) arithmetic and the documented cycle timing.
module tb_vga_fb_port_ctrl;

  localparam int W    = 320;
  localparam int H    = 240;
  localparam int NPIX = W * H;

  logic CLK_50MHz = 1'b0;
  logic RST_N     = 1'b0;

  always #10 CLK_50MHz = ~CLK_50MHz;

  vga_fb_port_ctrl_if #(.ADDR_W(17), .DATA_W(12)) bus ();

  vga_fb_port_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(17), .DATA_W(12)) dut (
    .CLK_50MHz (CLK_50MHz),
    .RST_N     (RST_N),
    .bus       (bus)
  );

  logic [11:0] ram     [NPIX];
  logic [11:0] ref_mem [NPIX];
  int          wq_x[$];
  int          wq_y[$];
  int          n_checks = 0;
  int          n_fails  = 0;

  // Framebuffer model: synchronous write, registered read of WA1.
  always @(posedge CLK_50MHz) begin
    if (bus.RAM_WE && int'(bus.RAM_WA1) < NPIX) ram[bus.RAM_WA1] <= bus.RAM_WD;
    if (int'(bus.RAM_WA1) < NPIX) bus.RAM_RD1 <= ram[bus.RAM_WA1];
    else                          bus.RAM_RD1 <= 12'h000;
  end

  task automatic step();
    @(posedge CLK_50MHz);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MCU_WE     = 1'b0;
    bus.MCU_RE     = 1'b0;
    bus.MCU_X      = 9'd0;
    bus.MCU_Y      = 8'd0;
    bus.MCU_WD     = 12'h000;
    bus.FILL_START = 1'b0;
    bus.FILL_COLOR = 12'h000;
  endtask

  task automatic test_reset();
    RST_N          = 1'b0;
    bus.MCU_WE     = 1'b1;
    bus.MCU_X      = 9'd3;
    bus.MCU_Y      = 8'd3;
    bus.MCU_WD     = 12'hFFF;
    bus.FILL_START = 1'b1;
    step();
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL reset_ram_we: got %0b want 0", bus.RAM_WE); end
    n_checks++; if (bus.RAM_WA1 !== 17'd0) begin n_fails++; $display("FAIL reset_ram_wa1: got %0d want 0", bus.RAM_WA1); end
    n_checks++; if (bus.RAM_WD !== 12'h000) begin n_fails++; $display("FAIL reset_ram_wd: got %h want 000", bus.RAM_WD); end
    n_checks++; if (bus.MCU_RD !== 12'h000) begin n_fails++; $display("FAIL reset_mcu_rd: got %h want 000", bus.MCU_RD); end
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL reset_rd_valid: got %0b want 0", bus.MCU_RD_VALID); end
    n_checks++; if (bus.FILL_DONE !== 1'b0) begin n_fails++; $display("FAIL reset_fill_done: got %0b want 0", bus.FILL_DONE); end
    n_checks++; if (bus.MCU_BUSY !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %0b want 0", bus.MCU_BUSY); end
    idle_inputs();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_write_basic();
    bus.MCU_WE = 1'b1; bus.MCU_X = 9'd5; bus.MCU_Y = 8'd2; bus.MCU_WD = 12'hABC;
    step();
    idle_inputs();
    n_checks++; if (bus.RAM_WE !== 1'b1) begin n_fails++; $display("FAIL wr_we: got %0b want 1", bus.RAM_WE); end
    n_checks++; if (bus.RAM_WA1 !== 17'd645) begin n_fails++; $display("FAIL wr_addr: got %0d want 645", bus.RAM_WA1); end
    n_checks++; if (bus.RAM_WD !== 12'hABC) begin n_fails++; $display("FAIL wr_data: got %h want abc", bus.RAM_WD); end
    ref_mem[2*W+5] = 12'hABC;
    wq_x.push_back(5); wq_y.push_back(2);
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL wr_we_drop: got %0b want 0", bus.RAM_WE); end
  endtask

  task automatic test_read_basic();
    bus.MCU_RE = 1'b1; bus.MCU_X = 9'd5; bus.MCU_Y = 8'd2;
    step();
    idle_inputs();
    n_checks++; if (bus.MCU_BUSY !== 1'b1) begin n_fails++; $display("FAIL rd_busy_n1: got %0b want 1", bus.MCU_BUSY); end
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL rd_no_we: got %0b want 0", bus.RAM_WE); end
    step();
    n_checks++; if (bus.MCU_BUSY !== 1'b1) begin n_fails++; $display("FAIL rd_busy_n2: got %0b want 1", bus.MCU_BUSY); end
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL rd_valid_n2: got %0b want 0", bus.MCU_RD_VALID); end
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b1) begin n_fails++; $display("FAIL rd_valid_n3: got %0b want 1", bus.MCU_RD_VALID); end
    n_checks++; if (bus.MCU_RD !== 12'hABC) begin n_fails++; $display("FAIL rd_data: got %h want abc", bus.MCU_RD); end
    n_checks++; if (bus.MCU_BUSY !== 1'b0) begin n_fails++; $display("FAIL rd_busy_n3: got %0b want 0", bus.MCU_BUSY); end
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL rd_valid_n4: got %0b want 0", bus.MCU_RD_VALID); end
  endtask

  task automatic test_out_of_range();
    bus.MCU_WE = 1'b1; bus.MCU_X = 9'd320; bus.MCU_Y = 8'd0; bus.MCU_WD = 12'h123;
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL oor_wr_x: got we=%0b want 0", bus.RAM_WE); end
    bus.MCU_X = 9'd0; bus.MCU_Y = 8'd240;
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL oor_wr_y: got we=%0b want 0", bus.RAM_WE); end
    // Plant data at the address an unchecked X=400,Y=3 would alias to (1360).
    bus.MCU_X = 9'd80; bus.MCU_Y = 8'd4; bus.MCU_WD = 12'h5A5;
    step();
    ref_mem[4*W+80] = 12'h5A5;
    wq_x.push_back(80); wq_y.push_back(4);
    bus.MCU_WE = 1'b0; bus.MCU_RE = 1'b1; bus.MCU_X = 9'd400; bus.MCU_Y = 8'd3;
    step();
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b1) begin n_fails++; $display("FAIL oor_rd_x_valid: got %0b want 1", bus.MCU_RD_VALID); end
    n_checks++; if (bus.MCU_RD !== 12'h000) begin n_fails++; $display("FAIL oor_rd_x_data: got %h want 000", bus.MCU_RD); end
    bus.MCU_RE = 1'b1; bus.MCU_X = 9'd0; bus.MCU_Y = 8'd240;
    step();
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b1) begin n_fails++; $display("FAIL oor_rd_y_valid: got %0b want 1", bus.MCU_RD_VALID); end
    n_checks++; if (bus.MCU_RD !== 12'h000) begin n_fails++; $display("FAIL oor_rd_y_data: got %h want 000", bus.MCU_RD); end
    step();
  endtask

  task automatic test_back_to_back();
    int x, y;
    logic [11:0] d;
    bit in_rng;
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 335);
      y = $urandom_range(0, 250);
      d = 12'($urandom);
      bus.MCU_WE = 1'b1;
      bus.MCU_RE = 1'($urandom_range(0, 1));
      bus.MCU_X  = 9'(x);
      bus.MCU_Y  = 8'(y);
      bus.MCU_WD = d;
      step();
      in_rng = (x < W) && (y < H);
      n_checks++; if (bus.RAM_WE !== in_rng) begin n_fails++; $display("FAIL b2b_we[%0d] x=%0d y=%0d: got %0b want %0b", i, x, y, bus.RAM_WE, in_rng); end
      n_checks++; if (bus.MCU_BUSY !== 1'b0) begin n_fails++; $display("FAIL b2b_busy[%0d]: got %0b want 0", i, bus.MCU_BUSY); end
      if (in_rng) begin
        n_checks++; if (bus.RAM_WA1 !== 17'(y * W + x) || bus.RAM_WD !== d) begin
          n_fails++; $display("FAIL b2b_wr[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, bus.RAM_WA1, bus.RAM_WD, y * W + x, d);
        end
        ref_mem[y * W + x] = d;
        wq_x.push_back(x); wq_y.push_back(y);
      end
    end
    idle_inputs();
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL b2b_we_end: got %0b want 0", bus.RAM_WE); end
  endtask

  task automatic test_random_reads();
    int x, y, k;
    logic [11:0] exp_d;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) begin
        x = $urandom_range(W, 511);
        y = $urandom_range(0, 255);
        exp_d = 12'h000;
      end else begin
        k = $urandom_range(0, wq_x.size() - 1);
        x = wq_x[k];
        y = wq_y[k];
        exp_d = ref_mem[y * W + x];
      end
      bus.MCU_RE = 1'b1; bus.MCU_X = 9'(x); bus.MCU_Y = 8'(y);
      step();
      idle_inputs();
      n_checks++; if (bus.MCU_BUSY !== 1'b1) begin n_fails++; $display("FAIL rrd_busy[%0d]: got %0b want 1", i, bus.MCU_BUSY); end
      step();
      step();
      n_checks++; if (bus.MCU_RD_VALID !== 1'b1 || bus.MCU_RD !== exp_d) begin
        n_fails++; $display("FAIL rrd_data[%0d] x=%0d y=%0d: got valid=%0b data=%h want valid=1 data=%h", i, x, y, bus.MCU_RD_VALID, bus.MCU_RD, exp_d);
      end
      // Next request is issued in this same cycle (N+3).
    end
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL rrd_valid_end: got %0b want 0", bus.MCU_RD_VALID); end
  endtask

  task automatic test_reset_mid_read();
    bus.MCU_RE = 1'b1; bus.MCU_X = 9'd5; bus.MCU_Y = 8'd2;
    step();
    idle_inputs();
    step();
    RST_N = 1'b0;
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL rst_rd_valid: got %0b want 0", bus.MCU_RD_VALID); end
    n_checks++; if (bus.MCU_BUSY !== 1'b0) begin n_fails++; $display("FAIL rst_rd_busy: got %0b want 0", bus.MCU_BUSY); end
    RST_N = 1'b1;
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b0) begin n_fails++; $display("FAIL rst_rd_valid2: got %0b want 0", bus.MCU_RD_VALID); end
  endtask

  task automatic test_fill();
    int bad, first_bad;
    bus.FILL_START = 1'b1; bus.FILL_COLOR = 12'h00F;
    step();
    bus.FILL_START = 1'b0; bus.FILL_COLOR = 12'($urandom);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (bus.RAM_WE !== 1'b1 || bus.RAM_WA1 !== 17'(i) || bus.RAM_WD !== 12'h00F || bus.MCU_BUSY !== 1'b1) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      if (i == 99) begin
        bus.MCU_WE = 1'b1; bus.MCU_X = 9'd7; bus.MCU_Y = 8'd7; bus.MCU_WD = 12'hFFF;
        bus.FILL_START = 1'b1; bus.FILL_COLOR = 12'hF00;
      end
      if (i == 110) idle_inputs();
      step();
    end
    n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL fill_writes: got %0d bad cycles (first at %0d) want 0", bad, first_bad); end
    n_checks++; if (bus.FILL_DONE !== 1'b1) begin n_fails++; $display("FAIL fill_done: got %0b want 1", bus.FILL_DONE); end
    n_checks++; if (bus.RAM_WE !== 1'b0) begin n_fails++; $display("FAIL fill_we_end: got %0b want 0", bus.RAM_WE); end
    n_checks++; if (bus.MCU_BUSY !== 1'b0) begin n_fails++; $display("FAIL fill_busy_end: got %0b want 0", bus.MCU_BUSY); end
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 12'h00F;
    step();
    n_checks++; if (bus.FILL_DONE !== 1'b0 || bus.RAM_WE !== 1'b0) begin
      n_fails++; $display("FAIL fill_after: got done=%0b we=%0b want 0 0", bus.FILL_DONE, bus.RAM_WE);
    end
    bus.MCU_RE = 1'b1; bus.MCU_X = 9'd7; bus.MCU_Y = 8'd7;
    step();
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.MCU_RD !== 12'h00F) begin n_fails++; $display("FAIL fill_readback: got %h want 00f", bus.MCU_RD); end
  endtask

  task automatic test_fill_after_read();
    bus.MCU_RE = 1'b1; bus.MCU_X = 9'd5; bus.MCU_Y = 8'd2;
    bus.FILL_START = 1'b1; bus.FILL_COLOR = 12'h3C3;
    step();
    bus.MCU_RE = 1'b0; bus.FILL_START = 1'b0;
    n_checks++; if (bus.MCU_BUSY !== 1'b1 || bus.RAM_WE !== 1'b0) begin
      n_fails++; $display("FAIL far_n1: got busy=%0b we=%0b want 1 0", bus.MCU_BUSY, bus.RAM_WE);
    end
    step();
    step();
    n_checks++; if (bus.MCU_RD_VALID !== 1'b1 || bus.MCU_RD !== ref_mem[2*W+5]) begin
      n_fails++; $display("FAIL far_rd: got valid=%0b data=%h want 1 %h", bus.MCU_RD_VALID, bus.MCU_RD, ref_mem[2*W+5]);
    end
    n_checks++; if (bus.MCU_BUSY !== 1'b1 || bus.RAM_WE !== 1'b0) begin
      n_fails++; $display("FAIL far_n3: got busy=%0b we=%0b want 1 0", bus.MCU_BUSY, bus.RAM_WE);
    end
    step();
    n_checks++; if (bus.RAM_WE !== 1'b1 || bus.RAM_WA1 !== 17'd0 || bus.RAM_WD !== 12'h3C3) begin
      n_fails++; $display("FAIL far_fill0: got we=%0b addr=%0d data=%h want 1 0 3c3", bus.RAM_WE, bus.RAM_WA1, bus.RAM_WD);
    end
    idle_inputs();
    RST_N = 1'b0;
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0 || bus.MCU_BUSY !== 1'b0) begin
      n_fails++; $display("FAIL far_reset: got we=%0b busy=%0b want 0 0", bus.RAM_WE, bus.MCU_BUSY);
    end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_fill_with_write_reset();
    int bad, dones;
    logic [11:0] d, c;
    d = 12'($urandom);
    c = 12'($urandom);
    bus.MCU_WE = 1'b1; bus.MCU_X = 9'd1; bus.MCU_Y = 8'd0; bus.MCU_WD = d;
    bus.FILL_START = 1'b1; bus.FILL_COLOR = c;
    step();
    bus.MCU_WE = 1'b0; bus.FILL_START = 1'b0;
    n_checks++; if (bus.RAM_WE !== 1'b1 || bus.RAM_WA1 !== 17'd1 || bus.RAM_WD !== d) begin
      n_fails++; $display("FAIL fww_mcu: got we=%0b addr=%0d data=%h want 1 1 %h", bus.RAM_WE, bus.RAM_WA1, bus.RAM_WD, d);
    end
    n_checks++; if (bus.MCU_BUSY !== 1'b1) begin n_fails++; $display("FAIL fww_busy: got %0b want 1", bus.MCU_BUSY); end
    step();
    n_checks++; if (bus.RAM_WE !== 1'b1 || bus.RAM_WA1 !== 17'd0 || bus.RAM_WD !== c) begin
      n_fails++; $display("FAIL fww_fill0: got we=%0b addr=%0d data=%h want 1 0 %h", bus.RAM_WE, bus.RAM_WA1, bus.RAM_WD, c);
    end
    bad = 0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (bus.RAM_WE !== 1'b1 || bus.RAM_WA1 !== 17'(i) || bus.RAM_WD !== c) bad++;
    end
    n_checks++; if (bad !== 0 || bus.RAM_WA1 !== 17'd1000) begin
      n_fails++; $display("FAIL fww_seq: got %0b bad=%0d addr=%0d want bad=0 addr=1000", bus.RAM_WE, bad, bus.RAM_WA1);
    end
    RST_N = 1'b0;
    step();
    n_checks++; if (bus.RAM_WE !== 1'b0 || bus.FILL_DONE !== 1'b0) begin
      n_fails++; $display("FAIL fww_reset: got we=%0b done=%0b want 0 0", bus.RAM_WE, bus.FILL_DONE);
    end
    RST_N = 1'b1;
    dones = 0; bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.FILL_DONE !== 1'b0) dones++;
      if (bus.RAM_WE !== 1'b0) bad++;
    end
    n_checks++; if (dones !== 0) begin n_fails++; $display("FAIL fww_no_done: got %0d pulses want 0", dones); end
    n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL fww_no_writes: got %0d write cycles want 0", bad); end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 12'h000;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_out_of_range();
    test_back_to_back();
    test_random_reads();
    test_reset_mid_read();
    test_fill();
    test_fill_after_read();
    test_fill_with_write_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
